alu_sequencer: RTL and testbench

Issue controller that sits between an instruction source and the `TotalALU` datapath. It accepts one ALU operation at a time over a valid/ready handshake and drives `dataA`/`dataB`/`Signal` for as many cycles as the operation needs. For MULTU it waits out the multiplier, then issues MFHI and MFLO itself, so requesters never hand-sequence the Hi/Lo moves. Results return on a buffered valid/ready response port.

---
 rtl/alu_seq_pkg.sv | 24 ++
 rtl/alu_seq_if.sv | 23 ++
 rtl/alu_seq_timer.sv | 20 ++
 rtl/alu_sequencer.sv | 169 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: funct codes, FSM state type and the legal-funct helper
// shared by the ALU sequencer and its bench.
package alu_seq_pkg;

  localparam logic [5:0] FN_SLL   = 6'd0;
  localparam logic [5:0] FN_MFHI  = 6'd16;
  localparam logic [5:0] FN_MFLO  = 6'd18;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_SUB   = 6'd34;
  localparam logic [5:0] FN_AND   = 6'd36;
  localparam logic [5:0] FN_OR    = 6'd37;
  localparam logic [5:0] FN_SLT   = 6'd42;

  typedef enum logic [3:0] {
    IDLE, EXEC, MUL, DRAIN, MFHI, MFLO, RESP, RESP_HI, RESP_LO
  } alu_seq_state_t;

  // Requester-visible ops only; MFHI/MFLO are issued internally.
  function automatic logic is_legal(input logic [5:0] f);
    return f inside {FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT, FN_SLL, FN_MULTU};
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: request and response valid/ready channels of the ALU sequencer.
interface alu_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_funct;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_last;
  logic        rsp_err;

  modport master (
    output req_valid, req_funct, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_last, rsp_err
  );

  modport slave (
    input  req_valid, req_funct, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_last, rsp_err
  );
endinterface

// File: rtl/alu_seq_timer.sv
// alu_seq_timer: loadable 32-bit down-counter; o_zero flags a count of 0.
module alu_seq_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic [31:0] i_load_val,
  input  logic        i_dec,
  output logic        o_zero
);
  logic [31:0] r_count;

  // Load wins over decrement; the count never wraps below zero.
  always_ff @(posedge clk) begin
    if (reset)                         r_count <= '0;
    else if (i_load)                   r_count <= i_load_val;
    else if (i_dec && r_count != '0)   r_count <= r_count - 32'd1;
  end

  assign o_zero = (r_count == '0);
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: issues one ALU op at a time to TotalALU, sequences
// MULTU -> drain -> MFHI -> MFLO itself, and returns buffered response beats.
// Optional feature macro: ALU_SEQ_ILLEGAL_CHK_EN (reject unsupported funct codes).
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int MUL_CYCLES   = 33,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  alu_seq_if.slave    bus,
  output logic [31:0] alu_dataA,
  output logic [31:0] alu_dataB,
  output logic [5:0]  alu_signal,
  input  logic [31:0] alu_out
);

  alu_seq_state_t r_state, w_state_nxt;
  logic [5:0]  r_funct;
  logic [31:0] r_a, r_b, r_hi, r_lo;
  logic        r_req_ready, r_rsp_valid, r_rsp_last;
  logic [31:0] r_rsp_data;
  logic [5:0]  r_alu_signal;
  logic [31:0] r_alu_a, r_alu_b;
  logic        w_accept, w_illegal;
  logic        w_tmr_load, w_tmr_dec, w_tmr_zero;
  logic [31:0] w_tmr_val;

  assign w_accept = bus.req_valid && r_req_ready;

`ifdef ALU_SEQ_ILLEGAL_CHK_EN
  logic r_rsp_err;
  assign w_illegal   = !is_legal(bus.req_funct);
  assign bus.rsp_err = r_rsp_err;

  // Error flag belongs to the operation being accepted.
  always_ff @(posedge clk) begin
    if (reset)                               r_rsp_err <= 1'b0;
    else if (r_state == IDLE && w_accept)    r_rsp_err <= w_illegal;
  end
`else
  assign w_illegal   = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  alu_seq_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_dec      (w_tmr_dec),
    .o_zero     (w_tmr_zero)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and timer control; timer loads N-1 as MUL/DRAIN is entered.
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_load  = 1'b0;
    w_tmr_val   = '0;
    w_tmr_dec   = 1'b0;
    case (r_state)
      IDLE: if (w_accept) begin
        if (w_illegal) w_state_nxt = RESP;
        else if (bus.req_funct == FN_MULTU) begin
          w_state_nxt = MUL;
          w_tmr_load  = 1'b1;
          w_tmr_val   = 32'(MUL_CYCLES - 1);
        end else w_state_nxt = EXEC;
      end
      EXEC:  w_state_nxt = RESP;
      MUL: if (w_tmr_zero) begin
        w_state_nxt = DRAIN;
        w_tmr_load  = 1'b1;
        w_tmr_val   = 32'(DRAIN_CYCLES - 1);
      end else w_tmr_dec = 1'b1;
      DRAIN: if (w_tmr_zero) w_state_nxt = MFHI; else w_tmr_dec = 1'b1;
      MFHI:    w_state_nxt = MFLO;
      MFLO:    w_state_nxt = RESP_HI;
      RESP:    if (bus.rsp_ready) w_state_nxt = IDLE;
      RESP_HI: if (bus.rsp_ready) w_state_nxt = RESP_LO;
      RESP_LO: if (bus.rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand latch at accept; Hi/Lo capture at the end of MFHI/MFLO.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_funct <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      if (w_accept) begin
        r_funct <= bus.req_funct;
        r_a     <= bus.req_a;
        r_b     <= bus.req_b;
      end
      if (r_state == MFHI) r_hi <= alu_out;
      if (r_state == MFLO) r_lo <= alu_out;
    end
  end

  // Registered outputs decoded from the state being entered; response data
  // only changes on beat-producing transitions so it holds under backpressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_req_ready  <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_last   <= 1'b0;
      r_alu_signal <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
    end else begin
      r_req_ready  <= (w_state_nxt == IDLE);
      r_rsp_valid  <= (w_state_nxt inside {RESP, RESP_HI, RESP_LO});
      r_alu_signal <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      case (w_state_nxt)
        EXEC, MUL: begin
          r_alu_signal <= w_accept ? bus.req_funct : r_funct;
          r_alu_a      <= w_accept ? bus.req_a     : r_a;
          r_alu_b      <= w_accept ? bus.req_b     : r_b;
        end
        MFHI:    r_alu_signal <= FN_MFHI;
        MFLO:    r_alu_signal <= FN_MFLO;
        default: ;
      endcase
      case (r_state)
        IDLE: if (w_accept && w_illegal) begin
          r_rsp_data <= '0;
          r_rsp_last <= 1'b1;
        end
        EXEC: begin
          r_rsp_data <= alu_out;
          r_rsp_last <= 1'b1;
        end
        MFLO: begin
          r_rsp_data <= r_hi;
          r_rsp_last <= 1'b0;
        end
        RESP_HI: if (bus.rsp_ready) begin
          r_rsp_data <= r_lo;
          r_rsp_last <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_last  = r_rsp_last;
  assign alu_signal    = r_alu_signal;
  assign alu_dataA     = r_alu_a;
  assign alu_dataB     = r_alu_b;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: table vectors, hand-written MULTU/backpressure/reset
// sequences and a randomized run against a TotalALU stand-in.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  localparam int MULC = 33;
  localparam int DRNC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] alu_dataA, alu_dataB, alu_out;
  logic [5:0]  alu_signal;
  int          n_vec = 0;
  int          n_err = 0;
  int          n63 = 0;

  alu_seq_if bus();

  alu_sequencer #(.MUL_CYCLES(MULC), .DRAIN_CYCLES(DRNC)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .alu_dataA  (alu_dataA),
    .alu_dataB  (alu_dataB),
    .alu_signal (alu_signal),
    .alu_out    (alu_out)
  );

  always #5 clk = ~clk;

  // TotalALU stand-in: Hi/Lo only become the product if Signal=25 was held
  // for exactly MULC cycles, otherwise they are poisoned.
  logic [31:0] m_hi = 32'hDEADBEEF, m_lo = 32'hDEADBEEF, m_a = 0, m_b = 0;
  int          m_cnt = 0;
  always @(posedge clk) begin
    if (alu_signal == FN_MULTU) begin
      m_cnt <= m_cnt + 1;
      m_a   <= alu_dataA;
      m_b   <= alu_dataB;
    end else if (m_cnt != 0) begin
      if (m_cnt == MULC) {m_hi, m_lo} <= 64'(m_a) * 64'(m_b);
      else               {m_hi, m_lo} <= {2{32'hDEADBEEF}};
      m_cnt <= 0;
    end
  end

  always_comb begin
    case (alu_signal)
      FN_ADD:  alu_out = alu_dataA + alu_dataB;
      FN_SUB:  alu_out = alu_dataA - alu_dataB;
      FN_AND:  alu_out = alu_dataA & alu_dataB;
      FN_OR:   alu_out = alu_dataA | alu_dataB;
      FN_SLT:  alu_out = {31'b0, $signed(alu_dataA) < $signed(alu_dataB)};
      FN_SLL:  alu_out = alu_dataA << alu_dataB[4:0];
      FN_MFHI: alu_out = m_hi;
      FN_MFLO: alu_out = m_lo;
      default: alu_out = 32'hA5A50000 | 32'(alu_signal);
    endcase
  end

  always @(negedge clk) if (alu_signal == 6'd63) n63++;

  // Reference result of a single-cycle op, straight from the op definitions.
  function automatic logic [31:0] ref_op(input logic [5:0] f, input logic [31:0] a, b);
    case (f)
      FN_ADD: return a + b;
      FN_SUB: return a - b;
      FN_AND: return a & b;
      FN_OR:  return a | b;
      FN_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      FN_SLL: return a << b[4:0];
      default: return 32'hA5A50000 | 32'(f);
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_funct = f;
    bus.req_a     = a;
    bus.req_b     = b;
    for (int k = 0; k < 300; k++) begin
      if (bus.req_ready) break;
      @(negedge clk);
    end
    chk("req_accept", bus.req_ready, 1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  // Waits for rsp_valid; lat counts negedges since the accept edge (0 = timeout).
  task automatic get_beat(output logic [31:0] d, output logic l, output logic e, output int lat);
    lat = 0; d = '0; l = 1'b0; e = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        lat = k; d = bus.rsp_data; l = bus.rsp_last; e = bus.rsp_err;
        break;
      end
    end
  endtask

  typedef struct {
    logic [5:0]  f;
    logic [31:0] a, b, data;
    logic        err;
    int          lat;
  } vec_t;

  typedef struct { logic [31:0] data; logic last; } beat_t;

  initial begin
    vec_t        vt[10];
    beat_t       expq[$];
    logic [31:0] d;
    logic        l, e;
    int          lat, bad, vcnt, n63_0;
    logic [63:0] p;
    logic [5:0]  ops[7];

    vt[0] = '{FN_ADD, 32'd5,          32'd7,  32'd12,         1'b0, 2};
    vt[1] = '{FN_SUB, 32'd3,          32'd5,  32'hFFFFFFFE,   1'b0, 2};
    vt[2] = '{FN_SLT, 32'd3,          32'd5,  32'd1,          1'b0, 2};
    vt[3] = '{FN_SLT, 32'hFFFFFFFF,   32'd1,  32'd1,          1'b0, 2};
    vt[4] = '{FN_SLT, 32'd5,          32'd3,  32'd0,          1'b0, 2};
    vt[5] = '{FN_AND, 32'd12,         32'd10, 32'd8,          1'b0, 2};
    vt[6] = '{FN_OR,  32'd12,         32'd10, 32'd14,         1'b0, 2};
    vt[7] = '{FN_SLL, 32'd1,          32'd4,  32'd16,         1'b0, 2};
    vt[8] = '{FN_ADD, 32'hFFFFFFFF,   32'd1,  32'd0,          1'b0, 2};
`ifdef ALU_SEQ_ILLEGAL_CHK_EN
    vt[9] = '{6'd63,  32'd9,          32'd9,  32'd0,          1'b1, 1};
`else
    vt[9] = '{6'd63,  32'd9,          32'd9,  32'hA5A5003F,   1'b0, 2};
`endif
    ops = '{FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT, FN_SLL, FN_MULTU};

    bus.req_valid = 1'b0; bus.req_funct = '0; bus.req_a = '0; bus.req_b = '0;
    bus.rsp_ready = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data",  bus.rsp_data, 0);
    chk("rst_rsp_last",  bus.rsp_last, 0);
    chk("rst_rsp_err",   bus.rsp_err, 0);
    chk("rst_alu_bus",   {alu_signal, alu_dataA, alu_dataB}, 0);

    // Table of single-beat ops
    n63_0 = n63;
    for (int i = 0; i < 10; i++) begin
      send(vt[i].f, vt[i].a, vt[i].b);
      get_beat(d, l, e, lat);
      chk($sformatf("vec%0d_data", i), d, vt[i].data);
      chk($sformatf("vec%0d_last", i), l, 1);
      chk($sformatf("vec%0d_err", i), e, vt[i].err);
      chk($sformatf("vec%0d_lat", i), lat, vt[i].lat);
    end
`ifdef ALU_SEQ_ILLEGAL_CHK_EN
    chk("sig63_cycles", n63 - n63_0, 0);
`else
    chk("sig63_cycles", n63 - n63_0, 1);
`endif

    // MULTU 65536*65536: Signal sequence, Hi at t+38, then Lo
    send(FN_MULTU, 32'd65536, 32'd65536);
    bad = 0; vcnt = 0;
    for (int k = 1; k <= 37; k++) begin
      @(negedge clk);
      if (k <= 33)      bad += (alu_signal != FN_MULTU);
      else if (k <= 35) bad += (alu_signal != 6'd0);
      else if (k == 36) bad += (alu_signal != FN_MFHI);
      else              bad += (alu_signal != FN_MFLO);
      vcnt += (bus.req_ready != 1'b0) + (bus.rsp_valid != 1'b0);
    end
    chk("mul_signal_seq", bad, 0);
    chk("mul_busy_flags", vcnt, 0);
    get_beat(d, l, e, lat);
    chk("mul1_hi_lat", lat, 1);
    chk("mul1_hi", {d, 31'b0, l}, {32'd1, 32'd0});
    get_beat(d, l, e, lat);
    chk("mul1_lo_lat", lat, 1);
    chk("mul1_lo", {d, 31'b0, l}, {32'd0, 32'd1});

    // MULTU FFFFFFFF*2 with 10 cycles of backpressure on each beat
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    send(FN_MULTU, 32'hFFFFFFFF, 32'd2);
    get_beat(d, l, e, lat);
    chk("mul2_hi_lat", lat, 38);
    chk("mul2_hi", {d, 31'b0, l}, {32'd1, 32'd0});
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      bad += (bus.rsp_valid !== 1'b1) + (bus.rsp_data !== 32'd1) +
             (bus.rsp_last !== 1'b0) + (bus.req_ready !== 1'b0) + (alu_signal !== 6'd0);
    end
    chk("mul2_hi_hold", bad, 0);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    get_beat(d, l, e, lat);
    chk("mul2_lo_lat", lat, 1);
    chk("mul2_lo", {d, 31'b0, l}, {32'hFFFFFFFE, 32'd1});
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      bad += (bus.rsp_valid !== 1'b1) + (bus.rsp_data !== 32'hFFFFFFFE) +
             (bus.rsp_last !== 1'b1) + (bus.req_ready !== 1'b0) + (alu_signal !== 6'd0);
    end
    chk("mul2_lo_hold", bad, 0);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mul2_done", {bus.rsp_valid, bus.req_ready}, 2'b01);

    // Reset at cycle t+20 of a MULTU
    send(FN_MULTU, 32'd7, 32'd9);
    repeat (19) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("mrst_req_ready", bus.req_ready, 1);
    chk("mrst_rsp", {bus.rsp_valid, bus.rsp_data, bus.rsp_last, bus.rsp_err}, 0);
    chk("mrst_alu_bus", {alu_signal, alu_dataA, alu_dataB}, 0);
    vcnt = 0;
    repeat (50) begin
      @(negedge clk);
      vcnt += bus.rsp_valid;
    end
    chk("mrst_no_beat", vcnt, 0);
    send(FN_AND, 32'd12, 32'd10);
    get_beat(d, l, e, lat);
    chk("mrst_and", {d, 31'b0, l}, {32'd8, 32'd1});

    // Randomized ops with random response backpressure
    for (int n = 0; n < 40; n++) begin
      logic [5:0]  f;
      logic [31:0] a, b;
      int          guard;
      f = ops[$urandom_range(0, 6)];
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      if (f == FN_MULTU) begin
        p = 64'(a) * 64'(b);
        expq.push_back('{p[63:32], 1'b0});
        expq.push_back('{p[31:0], 1'b1});
      end else expq.push_back('{ref_op(f, a, b), 1'b1});
      send(f, a, b);
      guard = 0;
      while (expq.size() != 0 && guard < 500) begin
        @(negedge clk);
        guard++;
        bus.rsp_ready = $urandom_range(0, 1);
        if (bus.rsp_valid && bus.rsp_ready) begin
          chk($sformatf("rnd%0d_data", n), bus.rsp_data, expq[0].data);
          chk($sformatf("rnd%0d_last", n), bus.rsp_last, expq[0].last);
          chk($sformatf("rnd%0d_err", n), bus.rsp_err, 0);
          void'(expq.pop_front());
        end
      end
      chk($sformatf("rnd%0d_drained", n), expq.size(), 0);
      expq.delete();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
